// File: rtl/cpu_control.sv
// Instruction-sequencing controller for cpu16: decodes ROM words and runs a req/ack data-memory handshake.
// Optional memory timeout (busError + HALT) is enabled by defining CPU_CONTROL_MEM_TIMEOUT_EN.
module cpu_control #(
  parameter int DataWidth     = 16,
  parameter int AddrWidth     = 16,
  parameter int TimeoutCycles = 255
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [15:0]          instr,
  input  logic [DataWidth-1:0] regReadData1,
  input  logic [DataWidth-1:0] regReadData2,
  input  logic [DataWidth:0]   aluOut,
  input  logic                 aluZero,
  input  logic                 aluCarry,
  input  logic                 aluConditionMet,
  input  logic                 memAck,
  input  logic [DataWidth-1:0] memRdata,
  output logic                 pcAdvance,
  output logic                 aluEnable,
  output logic                 regWriteEnable,
  output logic [2:0]           regWriteAddr,
  output logic [2:0]           regReadAddr1,
  output logic [2:0]           regReadAddr2,
  output logic [DataWidth-1:0] regWriteData,
  output logic                 memReq,
  output logic                 memWe,
  output logic [AddrWidth-1:0] memAddr,
  output logic [DataWidth-1:0] memWdata,
  output logic                 haltFlag,
  output logic                 zeroFlag,
  output logic                 carryFlag,
  output logic                 busError
);

  typedef enum logic [1:0] {EXEC = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_t;

  state_t               state;
  logic [1:0]           op;
  logic [2:0]           dest;
  logic                 is_load;
  logic                 timeout_hit;
  logic [AddrWidth-1:0] next_addr;
  logic                 unused_carry;

  assign op           = instr[15:14];
  assign next_addr    = AddrWidth'(regReadData1) + AddrWidth'(instr[6:0]);
  assign haltFlag     = (state == HALT);
  // ALU carry reaches the flag through aluCarry, never through the write-back path
  assign unused_carry = aluOut[DataWidth];

`ifdef CPU_CONTROL_MEM_TIMEOUT_EN
  localparam int CntW = (TimeoutCycles > 255) ? $clog2(TimeoutCycles + 1) : 8;
  logic [CntW-1:0] wait_cnt;

  // wait_cnt is 0 in the first MEM_WAIT cycle, so TimeoutCycles-1 marks the last allowed one
  assign timeout_hit = (state == MEM_WAIT) && !memAck && (wait_cnt == CntW'(TimeoutCycles - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wait_cnt <= '0;
      busError <= 1'b0;
    end else begin
      if (state == MEM_WAIT) wait_cnt <= wait_cnt + CntW'(1);
      else                   wait_cnt <= '0;
      if (timeout_hit) busError <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TimeoutCycles != 0);
  assign timeout_hit    = 1'b0;
  assign busError       = 1'b0;
`endif

  always_comb begin
    pcAdvance      = 1'b0;
    aluEnable      = 1'b0;
    regWriteEnable = 1'b0;
    regWriteAddr   = 3'd0;
    regReadAddr1   = 3'd0;
    regReadAddr2   = 3'd0;
    regWriteData   = '0;
    case (state)
      EXEC: begin
        case (op)
          2'b00: pcAdvance = (instr[2:0] != 3'b000);
          2'b01: begin
            regWriteEnable = 1'b1;
            regWriteAddr   = instr[13:11];
            regWriteData   = DataWidth'(instr[10:0]);
            pcAdvance      = 1'b1;
          end
          2'b11: begin
            aluEnable      = 1'b1;
            regReadAddr1   = instr[10:8];
            regReadAddr2   = instr[7:5];
            regWriteAddr   = instr[13:11];
            regWriteData   = aluOut[DataWidth-1:0];
            regWriteEnable = aluConditionMet;
            pcAdvance      = 1'b1;
          end
          default: begin
            regReadAddr1 = instr[10:8];
            regReadAddr2 = instr[13:11];
          end
        endcase
      end
      MEM_WAIT: begin
        if (memAck) begin
          pcAdvance = 1'b1;
          if (is_load) begin
            regWriteEnable = 1'b1;
            regWriteAddr   = dest;
            regWriteData   = memRdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= EXEC;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      dest      <= 3'd0;
      is_load   <= 1'b0;
      zeroFlag  <= 1'b0;
      carryFlag <= 1'b0;
    end else begin
      case (state)
        EXEC: begin
          case (op)
            2'b00: begin
              case (instr[2:0])
                3'b000:  state     <= HALT;
                3'b001:  zeroFlag  <= 1'b1;
                3'b010:  zeroFlag  <= 1'b0;
                3'b011:  carryFlag <= 1'b1;
                3'b100:  carryFlag <= 1'b0;
                default: ;
              endcase
            end
            2'b11: begin
              if (aluConditionMet) begin
                zeroFlag  <= aluZero;
                carryFlag <= aluCarry;
              end
            end
            2'b10: begin
              memReq   <= 1'b1;
              memWe    <= !instr[7];
              memAddr  <= next_addr;
              memWdata <= instr[7] ? '0 : regReadData2;
              dest     <= instr[13:11];
              is_load  <= instr[7];
              state    <= MEM_WAIT;
            end
            default: ;
          endcase
        end
        MEM_WAIT: begin
          if (memAck || timeout_hit) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            state    <= memAck ? EXEC : HALT;
          end
        end
        HALT:    state <= HALT;
        default: state <= EXEC;
      endcase
    end
  end

endmodule
